// File: rtl/serial_link_phy_tx_mc.sv
// serial_link_phy_tx_mc: multi-channel source-synchronous TX PHY.
// SDR/DDR chosen at run time; forwarded clocks and lanes are flop outputs.
module serial_link_phy_tx_mc #(
   parameter  int NumChannels = 1,
   parameter  int NumLanes    = 8,
   parameter  int MaxClkDiv   = 32,
   localparam int CW          = $clog2(MaxClkDiv) + 1,
   localparam int DW          = NumChannels * 2 * NumLanes,
   localparam int OW          = NumChannels * NumLanes
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   cfg_ddr_i,
   input  logic [CW-1:0]          clk_div_i,
   input  logic [CW-1:0]          clk_shift_start_i,
   input  logic [CW-1:0]          clk_shift_end_i,
   input  logic [NumChannels-1:0] channel_en_i,
   input  logic [DW-1:0]          data_out_i,
   input  logic                   data_out_valid_i,
   output logic                   data_out_ready_o,
   output logic                   busy_o,
   output logic                   cfg_err_o,
   output logic [NumChannels-1:0] ddr_rcv_clk_o,
   output logic [OW-1:0]          ddr_o
);

   typedef enum logic {
      S_IDLE,
      S_RUN
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [CW-1:0]          r_cnt;
   logic [CW-1:0]          w_cnt_nxt;
   logic                   r_err;
   logic                   w_err_nxt;
   logic                   r_ddr_q;
   logic [CW-1:0]          r_div_q;
   logic [CW-1:0]          r_ss_q;
   logic [CW-1:0]          r_se_q;
   logic [NumChannels-1:0] r_en_q;
   logic [DW-1:0]          r_data_q;
   logic                   w_ddr_nxt;
   logic [CW-1:0]          w_div_nxt;
   logic [CW-1:0]          w_ss_nxt;
   logic [CW-1:0]          w_se_nxt;
   logic [NumChannels-1:0] w_en_nxt;
   logic [DW-1:0]          w_data_nxt;
   logic [NumChannels-1:0] r_clk;
   logic [NumChannels-1:0] w_clk_nxt;
   logic [OW-1:0]          r_lane;
   logic [OW-1:0]          w_lane_nxt;
   logic                   w_legal;
   logic                   w_last;
   logic                   w_accept;
   logic                   w_load;
   logic                   w_tog;
   logic [CW-1:0]          w_half;

   assign w_legal = (clk_div_i >= CW'(2)) && !clk_div_i[0]
                 && (clk_div_i <= CW'(MaxClkDiv))
                 && (!cfg_ddr_i || (clk_div_i >= CW'(4)))
                 && (clk_shift_start_i < clk_shift_end_i)
                 && (clk_shift_end_i < clk_div_i)
                 && (channel_en_i != '0);

   assign w_last   = (r_state == S_RUN) && (r_cnt == r_div_q - CW'(1));
   assign w_accept = (r_state == S_IDLE) && data_out_valid_i && w_legal;
   assign w_load   = w_accept || (w_last && data_out_valid_i);
   assign w_tog    = (r_state == S_RUN)
                  && ((r_cnt == r_ss_q) || (r_cnt == r_se_q));

   // Shadow config only moves on an IDLE acceptance
   assign w_ddr_nxt  = w_accept ? cfg_ddr_i         : r_ddr_q;
   assign w_div_nxt  = w_accept ? clk_div_i         : r_div_q;
   assign w_ss_nxt   = w_accept ? clk_shift_start_i : r_ss_q;
   assign w_se_nxt   = w_accept ? clk_shift_end_i   : r_se_q;
   assign w_en_nxt   = w_accept ? channel_en_i      : r_en_q;
   assign w_data_nxt = w_load   ? data_out_i        : r_data_q;
   assign w_half     = w_div_nxt >> 1;

   assign data_out_ready_o = w_load && !rst_i;
   assign busy_o           = (r_state == S_RUN);
   assign cfg_err_o        = r_err;
   assign ddr_rcv_clk_o    = r_clk;
   assign ddr_o            = r_lane;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_err_nxt   = r_err;
      unique case (r_state)
         S_IDLE: begin
            w_cnt_nxt = '0;
            if (data_out_valid_i) begin
               w_err_nxt = !w_legal;
               if (w_legal) w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (w_last) begin
               w_cnt_nxt = '0;
               if (!data_out_valid_i) w_state_nxt = S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
      endcase
   end

   // Outputs are precomputed from next-cycle state so pads see only flops
   always_comb begin
      w_clk_nxt  = '0;
      w_lane_nxt = '0;
      for (int c = 0; c < NumChannels; c++) begin
         if ((w_state_nxt == S_RUN) && w_en_nxt[c]) begin
            w_clk_nxt[c] = w_tog ? ~r_clk[c] : r_clk[c];
            if (w_ddr_nxt && (w_cnt_nxt >= w_half))
               w_lane_nxt[c*NumLanes +: NumLanes] =
                  w_data_nxt[c*2*NumLanes+NumLanes +: NumLanes];
            else
               w_lane_nxt[c*NumLanes +: NumLanes] =
                  w_data_nxt[c*2*NumLanes +: NumLanes];
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_err    <= 1'b0;
         r_ddr_q  <= 1'b0;
         r_div_q  <= '0;
         r_ss_q   <= '0;
         r_se_q   <= '0;
         r_en_q   <= '0;
         r_data_q <= '0;
         r_clk    <= '0;
         r_lane   <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_err    <= w_err_nxt;
         r_ddr_q  <= w_ddr_nxt;
         r_div_q  <= w_div_nxt;
         r_ss_q   <= w_ss_nxt;
         r_se_q   <= w_se_nxt;
         r_en_q   <= w_en_nxt;
         r_data_q <= w_data_nxt;
         r_clk    <= w_clk_nxt;
         r_lane   <= w_lane_nxt;
      end
   end

endmodule

// File: tb/tb_serial_link_phy_tx_mc.sv
// tb_serial_link_phy_tx_mc: directed bench with a period-window model
// compared every cycle plus literal checks of the test scenarios.
module tb_serial_link_phy_tx_mc;

   localparam int NC = 2;
   localparam int NL = 8;
   localparam int CW = 6;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cfg_ddr = 1'b0;
   logic [CW-1:0] clk_div = '0;
   logic [CW-1:0] ss = '0;
   logic [CW-1:0] se = '0;
   logic [NC-1:0] en = '0;
   logic [31:0]   din = '0;
   logic          valid = 1'b0;
   logic          ready;
   logic          busy;
   logic          cfg_err;
   logic [NC-1:0] fclk;
   logic [15:0]   dout;

   int n_chk = 0;
   int n_fail = 0;

   serial_link_phy_tx_mc #(
      .NumChannels(NC),
      .NumLanes(NL),
      .MaxClkDiv(32)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .cfg_ddr_i(cfg_ddr),
      .clk_div_i(clk_div),
      .clk_shift_start_i(ss),
      .clk_shift_end_i(se),
      .channel_en_i(en),
      .data_out_i(din),
      .data_out_valid_i(valid),
      .data_out_ready_o(ready),
      .busy_o(busy),
      .cfg_err_o(cfg_err),
      .ddr_rcv_clk_o(fclk),
      .ddr_o(dout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [63:0] a,
                      input logic [63:0] e);
      n_chk++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", n, $time, a, e);
      end
   endtask

   function automatic bit legal(bit d, int p, int s0, int s1,
                                logic [NC-1:0] e);
      return (p >= 2) && (p % 2 == 0) && (p <= 32) && (!d || p >= 4)
          && (s0 < s1) && (s1 < p) && (e != 0);
   endfunction

   // Model: a word occupies P cycles; position k in the period alone
   // determines the clock level (high for ss < k <= se) and phit.
   bit            m_run = 0;
   int            m_k = 0;
   int            m_p = 0;
   int            m_ss = 0;
   int            m_se = 0;
   bit            m_ddr = 0;
   logic [NC-1:0] m_en = '0;
   logic [31:0]   m_word = '0;
   bit            m_err = 0;

   always @(negedge clk) begin
      logic [NC-1:0] e_clk;
      logic [15:0]   e_dout;
      bit            e_rdy;
      e_clk  = '0;
      e_dout = '0;
      e_rdy  = 0;
      if (rst) begin
         m_run = 0;
         m_err = 0;
      end else begin
         if (m_run) begin
            for (int c = 0; c < NC; c++) begin
               if (m_en[c]) begin
                  e_clk[c] = (m_k > m_ss) && (m_k <= m_se);
                  e_dout[c*NL +: NL] = (m_ddr && m_k >= m_p / 2)
                     ? m_word[c*16+8 +: 8] : m_word[c*16 +: 8];
               end
            end
            e_rdy = valid && (m_k == m_p - 1);
         end else begin
            e_rdy = valid && legal(cfg_ddr, int'(clk_div), int'(ss),
                                   int'(se), en);
         end
      end
      chk("model_ready", ready, e_rdy);
      chk("model_busy", busy, m_run);
      chk("model_cfg_err", cfg_err, m_err);
      chk("model_fclk", fclk, e_clk);
      chk("model_ddr_o", dout, e_dout);
      if (!rst) begin
         if (!m_run) begin
            if (valid) begin
               m_err = !legal(cfg_ddr, int'(clk_div), int'(ss),
                              int'(se), en);
               if (!m_err) begin
                  m_run  = 1;
                  m_k    = 0;
                  m_p    = int'(clk_div);
                  m_ss   = int'(ss);
                  m_se   = int'(se);
                  m_ddr  = cfg_ddr;
                  m_en   = en;
                  m_word = din;
               end
            end
         end else if (m_k == m_p - 1) begin
            m_k = 0;
            if (valid) m_word = din;
            else m_run = 0;
         end else begin
            m_k++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setcfg(input bit d, input int p, input int s0,
                         input int s1, input logic [NC-1:0] e);
      cfg_ddr = d;
      clk_div = CW'(p);
      ss      = CW'(s0);
      se      = CW'(s1);
      en      = e;
   endtask

   initial begin
      @(negedge clk);
      chk("reset_ready", ready, 1'b0);
      chk("reset_busy", busy, 1'b0);
      chk("reset_outputs", {cfg_err, fclk, dout}, '0);
      tick();
      rst = 1'b0;

      // 1: SDR P=4 shift 1/3, single word
      setcfg(0, 4, 1, 3, 2'b01);
      din = 32'h0000_00A5;
      valid = 1'b1;
      @(negedge clk);
      chk("t1_ready_c0", ready, 1'b1);
      for (int i = 1; i <= 5; i++) begin
         tick();
         valid = 1'b0;
         @(negedge clk);
         if (i <= 4) begin
            chk("t1_data", dout[7:0], 8'hA5);
            chk("t1_clk", fclk[0], (i >= 3));
         end else begin
            chk("t1_idle", {busy, fclk, dout}, '0);
         end
      end

      // 2: DDR P=4 shift 0/2, two channels, back-to-back
      tick();
      setcfg(1, 4, 0, 2, 2'b11);
      din = {16'hABCD, 16'h1234};
      valid = 1'b1;
      @(negedge clk);
      chk("t2_ready_c0", ready, 1'b1);
      for (int i = 1; i <= 8; i++) begin
         logic [7:0] exp0 [8];
         exp0 = '{8'h34, 8'h34, 8'h12, 8'h12, 8'h78, 8'h78, 8'h56, 8'h56};
         tick();
         if (i == 1) din = {16'hEF01, 16'h5678};
         if (i == 5) valid = 1'b0;
         @(negedge clk);
         chk("t2_ch0", dout[7:0], exp0[i-1]);
         chk("t2_clk", fclk, ((i % 4 == 2) || (i % 4 == 3)) ? 2'b11 : 2'b00);
         if (i <= 4) chk("t2_ready", ready, (i == 4));
      end
      chk("t2_ch1_last", dout[15:8], 8'hEF);

      // 3: illegal configs, then legal acceptance
      for (int j = 0; j < 4; j++) begin
         tick();
         unique case (j)
            0: setcfg(0, 3, 0, 1, 2'b01);
            1: setcfg(1, 2, 0, 1, 2'b01);
            2: setcfg(0, 4, 1, 4, 2'b01);
            default: setcfg(0, 4, 0, 2, 2'b00);
         endcase
         valid = 1'b1;
         @(negedge clk);
         chk("t3_ill_ready", ready, 1'b0);
         tick();
         valid = 1'b0;
         @(negedge clk);
         chk("t3_err", cfg_err, 1'b1);
         chk("t3_quiet", {busy, fclk, dout}, '0);
      end
      tick();
      setcfg(0, 2, 0, 1, 2'b01);
      din = 32'h0000_0066;
      valid = 1'b1;
      @(negedge clk);
      chk("t3_legal_ready", ready, 1'b1);
      tick();
      valid = 1'b0;
      @(negedge clk);
      chk("t3_err_clear", cfg_err, 1'b0);
      chk("t3_busy", busy, 1'b1);
      repeat (3) tick();

      // 4: only channel 1 enabled, SDR P=2
      setcfg(0, 2, 0, 1, 2'b10);
      din = {16'h003C, 16'h0055};
      valid = 1'b1;
      tick();
      valid = 1'b0;
      @(negedge clk);
      chk("t4_data_c1", dout, 16'h3C00);
      tick();
      @(negedge clk);
      chk("t4_clk_c2", fclk, 2'b10);
      repeat (2) tick();

      // 5: live config changes during RUN are ignored
      setcfg(1, 4, 0, 2, 2'b11);
      din = {16'h9988, 16'h2211};
      valid = 1'b1;
      tick();
      valid = 1'b0;
      setcfg(0, 8, 1, 5, 2'b01);
      tick();
      tick();
      @(negedge clk);
      chk("t5_hi_phit", dout, 16'h9922);
      chk("t5_clk", fclk, 2'b11);
      repeat (3) tick();

      // 6: async reset mid-period (cnt = 2, P = 8)
      setcfg(0, 8, 1, 5, 2'b01);
      din = 32'h0000_0F77;
      valid = 1'b1;
      tick();
      valid = 1'b0;
      repeat (2) tick();
      #1;
      chk("t6_pre_clk", fclk, 2'b01);
      rst = 1'b1;
      #1;
      chk("t6_rst_out", {ready, busy, cfg_err, fclk, dout}, '0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("t6_post_busy", busy, 1'b0);
      tick();
      valid = 1'b1;
      @(negedge clk);
      chk("t6_reaccept", ready, 1'b1);
      tick();
      valid = 1'b0;
      @(negedge clk);
      chk("t6_data", dout[7:0], 8'h77);
      repeat (10) tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
